// File: rtl/mult_div_unit.sv
// Iterative signed multiply (Booth radix-2) / divide (restoring on magnitudes) producing HI/LO.
// Optional MULTDIV_DIVZERO_EXC_EN: divide by zero completes at once with a div_zero pulse.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             qm1_q, qm1_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic             quo_neg_q, quo_neg_d;
   logic             rem_neg_q, rem_neg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH:0]   booth_sum_s;
   logic [WIDTH:0]   rem_sh_s;
   logic [WIDTH:0]   rem_diff_s;
   logic             dz_start_s;

   function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
      return ~v + ONE_W;
   endfunction

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? neg_val(v) : v;
   endfunction

`ifdef MULTDIV_DIVZERO_EXC_EN
   assign dz_start_s = op & (b == {WIDTH{1'b0}});
`else
   assign dz_start_s = 1'b0;
`endif

   // Single-step datapath: Booth add/sub on a one-bit-wider accumulator, restoring trial subtract
   always_comb begin
      case ({q_q[0], qm1_q})
         2'b01:   booth_sum_s = acc_q + {m_q[WIDTH-1], m_q};
         2'b10:   booth_sum_s = acc_q - {m_q[WIDTH-1], m_q};
         default: booth_sum_s = acc_q;
      endcase
      rem_sh_s   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      rem_diff_s = rem_sh_s - {1'b0, m_q};
   end

   // Control FSM and operand/result register next-state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      acc_d     = acc_q;
      q_d       = q_q;
      qm1_d     = qm1_q;
      m_d       = m_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dz_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && dz_start_s) begin
               done_d = 1'b1;
               dz_d   = 1'b1;
            end else if (start) begin
               state_d   = CALC;
               cnt_d     = {CNT_W{1'b0}};
               op_d      = op;
               acc_d     = {(WIDTH+1){1'b0}};
               qm1_d     = 1'b0;
               quo_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
               rem_neg_d = a[WIDTH-1];
               if (op) begin
                  q_d = abs_val(a);
                  m_d = abs_val(b);
               end else begin
                  q_d = b;
                  m_d = a;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (op_q) begin
               // remainder stays below |b| <= 2^(W-1), so bit W of the trial result is the borrow
               if (!rem_diff_s[WIDTH]) begin
                  acc_d = rem_diff_s;
                  q_d   = {q_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = rem_sh_s;
                  q_d   = {q_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_d = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
               q_d   = {booth_sum_s[0], q_q[WIDTH-1:1]};
               qm1_d = q_q[0];
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIX;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + ONE_CNT;
            end
         end
         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (op_q) begin
               hi_d = rem_neg_q ? neg_val(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
               lo_d = quo_neg_q ? neg_val(q_q) : q_q;
            end else begin
               hi_d = acc_q[WIDTH-1:0];
               lo_d = q_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         op_q      <= 1'b0;
         acc_q     <= {(WIDTH+1){1'b0}};
         q_q       <= {WIDTH{1'b0}};
         qm1_q     <= 1'b0;
         m_q       <= {WIDTH{1'b0}};
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         qm1_q     <= qm1_d;
         m_q       <= m_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus hand-written multi-cycle sequences.
// Expectations for divide-by-zero follow MULTDIV_DIVZERO_EXC_EN when it is defined.
module tb_mult_div_unit;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int n_checks = 0;
   int n_fail   = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi_out   (hi_out),
      .lo_out   (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Issue one op; cyc = sample index (0 = first negedge after the accepting edge) where done is seen
   task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                         output int cyc, output int bcyc, output logic got_dz);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      bcyc = 0;
      while (!done && cyc < 100) begin
         if (busy) bcyc++;
         @(negedge clk);
         cyc++;
      end
      got_dz = div_zero;
   endtask

   initial begin
      int   cyc;
      int   bcyc;
      int   seen;
      logic dz;

      vecs[0]  = '{1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1]  = '{1'b0, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000};
      vecs[2]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{1'b1, 32'd100,        32'd7,        32'h00000002, 32'h0000000E};
      vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{1'b0, 32'h12345678,   32'h00000010, 32'h00000001, 32'h23456780};
      vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[8]  = '{1'b0, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
      vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
      vecs[10] = '{1'b0, 32'h80000000,   32'h00000001, 32'hFFFFFFFF, 32'h80000000};

      reset_n = 1'b0; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_dz",   {63'd0, div_zero}, 64'd0);
      check("rst_hilo", {hi_out, lo_out}, 64'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, bcyc, dz);
         check($sformatf("v%0d_latency", i), 64'(cyc), 64'd33);
         check($sformatf("v%0d_busy_cycles", i), 64'(bcyc), 64'd33);
         check($sformatf("v%0d_hi", i), {32'd0, hi_out}, {32'd0, vecs[i].hi});
         check($sformatf("v%0d_lo", i), {32'd0, lo_out}, {32'd0, vecs[i].lo});
         check($sformatf("v%0d_dz", i), {63'd0, dz}, 64'd0);
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
      end

      // divide by zero, 5 / 0
      run_op(1'b1, 32'd5, 32'd0, cyc, bcyc, dz);
`ifdef MULTDIV_DIVZERO_EXC_EN
      check("dz_latency", 64'(cyc), 64'd0);
      check("dz_flag", {63'd0, dz}, 64'd1);
      check("dz_hold_hi", {32'd0, hi_out}, 64'h00000000FFFFFFFF);
      check("dz_hold_lo", {32'd0, lo_out}, 64'h0000000080000000);
      @(negedge clk);
      check("dz_pulse_end", {62'd0, done, div_zero}, 64'd0);
      check("dz_no_busy", {63'd0, busy}, 64'd0);
`else
      check("dz_latency", 64'(cyc), 64'd33);
      check("dz_flag", {63'd0, dz}, 64'd0);
      check("dz_hi", {32'd0, hi_out}, 64'h0000000000000005);
      check("dz_lo", {32'd0, lo_out}, 64'h00000000FFFFFFFF);
      run_op(1'b1, 32'hFFFFFFFB, 32'd0, cyc, bcyc, dz);
      check("dzn_hi", {32'd0, hi_out}, 64'h00000000FFFFFFFB);
      check("dzn_lo", {32'd0, lo_out}, 64'h0000000000000001);
`endif

      // start pulsed mid-operation with new operands must be ignored
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'd7; b = 32'hFFFFFFFD;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cyc == 10) begin
            start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd100;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check("ign_latency", 64'(cyc), 64'd33);
      check("ign_result", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);

      // start held high across done: second op accepted on the done cycle
      @(negedge clk);
      start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
      @(negedge clk);
      cyc = 0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("b2b_first_latency", 64'(cyc), 64'd33);
      check("b2b_first_result", {hi_out, lo_out}, 64'h00000002_0000000E);
      op = 1'b0; a = 32'd6; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      check("b2b_accept_busy", {63'd0, busy}, 64'd1);
      cyc = 0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("b2b_second_latency", 64'(cyc), 64'd33);
      check("b2b_second_result", {hi_out, lo_out}, 64'h00000000_0000002A);

      // asynchronous reset at cycle 20 of a mult aborts without done
      @(negedge clk);
      start = 1'b1; op = 1'b0; a = 32'h12345678; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("abort_busy_before", {63'd0, busy}, 64'd1);
      reset_n = 1'b0;
      #1;
      check("abort_outputs", {29'd0, busy, done, div_zero, hi_out}, 64'd0);
      check("abort_lo", {32'd0, lo_out}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check("abort_no_done", 64'(seen), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
